// File: rtl/sonic_v1_15_avst_pkg.sv
// Shared Avalon-ST beat layout and framing rules for the 10G MAC TX/RX timing adapters.
// The 70-bit payload is {data, error, sop, eop, empty} with empty in the LSBs.
package sonic_v1_15_avst_pkg;

  localparam int AVST_DATA_W  = 64;
  localparam int AVST_EMPTY_W = 3;
  localparam int AVST_W       = AVST_DATA_W + AVST_EMPTY_W + 3;

  localparam int AVST_EMPTY_LSB = 0;
  localparam int AVST_EOP_BIT   = AVST_EMPTY_LSB + AVST_EMPTY_W;
  localparam int AVST_SOP_BIT   = AVST_EOP_BIT + 1;
  localparam int AVST_ERR_BIT   = AVST_SOP_BIT + 1;
  localparam int AVST_DATA_LSB  = AVST_ERR_BIT + 1;

  typedef struct packed {
    logic [AVST_DATA_W-1:0]  data;
    logic                    error;
    logic                    sop;
    logic                    eop;
    logic [AVST_EMPTY_W-1:0] empty;
  } avst_beat_t;

  typedef enum logic {
    FS_IDLE   = 1'b0,
    FS_IN_PKT = 1'b1
  } frame_state_e;

  // A sop always opens a packet (even an illegal one), so the tracker resyncs on it.
  function automatic frame_state_e frame_next(input frame_state_e s, input logic sop,
                                              input logic eop);
    if (sop) return eop ? FS_IDLE : FS_IN_PKT;
    if (eop) return FS_IDLE;
    return s;
  endfunction

  function automatic logic frame_violation(input frame_state_e s, input logic sop);
    return (s == FS_IDLE) ? !sop : sop;
  endfunction

endpackage

// File: rtl/sonic_v1_15_avst_sc_fifo.sv
// Single-clock FIFO with registered level and combinational head read; storage is never cleared.
// Push is ignored when full and pop when empty, so callers cannot corrupt the pointers.
module sonic_v1_15_avst_sc_fifo
  import sonic_v1_15_avst_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = AVST_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign push_ok = push_i && (level_q != FULL_LVL);
  assign pop_ok  = pop_i && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/blk_09c70e.sv
// 10G MAC TX timing adapter: ready-latency-0 sink to READY_LATENCY source via a small FIFO,
// with a framing checker and delivered-packet counter; out_valid only when delayed ready is high.
module blk_09c70e
  import sonic_v1_15_avst_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int READY_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [63:0]            in_data,
  input  logic                   in_error,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [2:0]             in_empty,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [63:0]            out_data,
  output logic                   out_error,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [2:0]             out_empty,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   proto_err,
  output logic [15:0]            pkt_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  avst_beat_t               in_beat;
  logic [AVST_W-1:0]        head_dat;
  logic [LW-1:0]            level;
  logic                     push, pop, rdy_dly;
  logic [READY_LATENCY-1:0] rdy_sr_q, rdy_sr_d;
  frame_state_e             state_q;
  logic                     proto_err_q;
  logic [15:0]              pkt_cnt_q, pkt_cnt_d;

  assign in_beat = avst_beat_t'{
    data:  in_data,
    error: in_error,
    sop:   in_startofpacket,
    eop:   in_endofpacket,
    empty: in_empty
  };

  // in_ready depends on registered level only, keeping in_valid/out_ready off this path.
  assign in_ready = (level < FULL_LVL);
  assign push     = in_valid && in_ready;

  always_comb begin
    rdy_sr_d    = rdy_sr_q;
    rdy_sr_d[0] = out_ready;
    for (int i = 1; i < READY_LATENCY; i++) rdy_sr_d[i] = rdy_sr_q[i-1];
  end

  assign rdy_dly   = rdy_sr_q[READY_LATENCY-1];
  assign out_valid = rdy_dly && (level != '0);
  assign pop       = out_valid;

  sonic_v1_15_avst_sc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AVST_W)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_dat_i (in_beat),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .level_o    (level)
  );

  assign out_data          = head_dat[AVST_DATA_LSB +: AVST_DATA_W];
  assign out_error         = head_dat[AVST_ERR_BIT];
  assign out_startofpacket = head_dat[AVST_SOP_BIT];
  assign out_endofpacket   = head_dat[AVST_EOP_BIT];
  assign out_empty         = head_dat[AVST_EMPTY_LSB +: AVST_EMPTY_W];

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pop && out_endofpacket) pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdy_sr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      rdy_sr_q  <= rdy_sr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Framing tracker watches accepted beats; violations are flagged but the beat still flows.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= FS_IDLE;
      proto_err_q <= 1'b0;
    end else if (push) begin
      state_q <= frame_next(state_q, in_startofpacket, in_endofpacket);
      if (frame_violation(state_q, in_startofpacket)) proto_err_q <= 1'b1;
    end
  end

  assign fifo_level = level;
  assign proto_err  = proto_err_q;
  assign pkt_count  = pkt_cnt_q;

endmodule

// File: tb/tb_blk_09c70e.sv
// Randomized and directed bench for the TX timing adapter with a queue-based scoreboard.
module tb_blk_09c70e;

  localparam int DEPTH = 4;
  localparam int RL    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_ready, in_valid;
  logic [63:0] in_data;
  logic        in_error, in_startofpacket, in_endofpacket;
  logic [2:0]  in_empty;
  logic        out_ready, out_valid;
  logic [63:0] out_data;
  logic        out_error, out_startofpacket, out_endofpacket;
  logic [2:0]  out_empty;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        proto_err;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  logic [69:0] sb[$];
  int          acc_cnt = 0;
  bit          m_in_pkt = 1'b0;
  bit          m_perr = 1'b0;
  int unsigned m_eops = 0;
  bit          hist[RL];

  blk_09c70e #(.DEPTH(DEPTH), .READY_LATENCY(RL)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_error          (in_error),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_error         (out_error),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .fifo_level        (fifo_level),
    .proto_err         (proto_err),
    .pkt_count         (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard at the falling edge: outputs first, then the beat the next edge accepts.
  always @(negedge clk) begin : mon
    int unsigned lvl;
    bit exp_ov;
    if (!reset_n) begin
      sb.delete();
      m_in_pkt = 1'b0;
      m_perr   = 1'b0;
      m_eops   = 0;
      for (int i = 0; i < RL; i++) hist[i] = 1'b0;
    end else begin
      lvl    = sb.size();
      exp_ov = hist[RL-1] && (lvl != 0);
      check("in_ready", 70'(in_ready), 70'(lvl < DEPTH));
      check("fifo_level", 70'(fifo_level), 70'(lvl));
      check("proto_err", 70'(proto_err), 70'(m_perr));
      check("pkt_count", 70'(pkt_count), 70'(m_eops % 65536));
      check("out_valid", 70'(out_valid), 70'(exp_ov));
      if (out_valid && exp_ov) begin
        logic [69:0] exp_beat;
        exp_beat = sb.pop_front();
        check("out_payload",
              {out_data, out_error, out_startofpacket, out_endofpacket, out_empty}, exp_beat);
        if (exp_beat[3]) m_eops++;
      end
      if (in_valid && lvl < DEPTH) begin
        sb.push_back({in_data, in_error, in_startofpacket, in_endofpacket, in_empty});
        acc_cnt++;
        if (m_in_pkt ? in_startofpacket : !in_startofpacket) m_perr = 1'b1;
        if (in_startofpacket)    m_in_pkt = !in_endofpacket;
        else if (in_endofpacket) m_in_pkt = 1'b0;
      end
      for (int i = RL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic e, input logic s, input logic p,
                           input logic [2:0] m);
    int prev;
    int guard;
    in_valid = 1'b1; in_data = d; in_error = e;
    in_startofpacket = s; in_endofpacket = p; in_empty = m;
    guard = 0;
    do begin
      prev = acc_cnt;
      tick();
      guard++;
    end while (acc_cnt == prev && guard < 100);
    in_valid = 1'b0;
    check("accept_timeout", 70'(acc_cnt != prev), 70'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    check("drain", 70'(sb.size()), 70'd0);
  endtask

  initial begin
    int prev, guard, sent;
    bit have, drv_in_pkt;
    logic [63:0] d;
    logic e, s, p;
    logic [2:0] m;

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_error = 1'b0;
    in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 70'(in_ready), 70'd1);
    check("rst_out_valid", 70'(out_valid), 70'd0);
    check("rst_level", 70'(fifo_level), 70'd0);
    check("rst_pkt_count", 70'(pkt_count), 70'd0);

    // Single-beat packet
    tick();
    out_ready = 1'b1;
    tick(); tick();
    send_beat(64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b1, 3'd3);
    drain();
    check("single_pkt_count", 70'(pkt_count), 70'd1);

    // Backpressure: six beats offered, four fit
    out_ready = 1'b0;
    repeat (3) tick();
    prev = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 64'hB0 + 64'(i); in_error = 1'b0;
      in_startofpacket = (i == 0) || (i > 3); in_endofpacket = (i >= 3); in_empty = 3'd0;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", 70'(acc_cnt - prev), 70'd4);
    check("bp_level", 70'(fifo_level), 70'd4);
    check("bp_in_ready", 70'(in_ready), 70'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ov_T", 70'(out_valid), 70'd0);
    tick();
    @(negedge clk);
    check("bp_ov_T1", 70'(out_valid), 70'd0);
    tick();
    @(negedge clk);
    check("bp_ov_T2", 70'(out_valid), 70'd1);
    check("bp_first_data", 70'(out_data), 70'h0B0);
    tick();
    drain();

    // Random traffic with legal framing and random sink readiness
    have = 1'b0; drv_in_pkt = 1'b0; sent = 0; guard = 0;
    d = '0; e = 1'b0; s = 1'b0; p = 1'b0; m = '0;
    while (sent < 1000 && guard < 10000) begin
      if (!have) begin
        d = {$urandom, $urandom};
        e = ($urandom_range(0, 15) == 0);
        s = !drv_in_pkt;
        p = ($urandom_range(0, 3) == 0);
        m = 3'($urandom_range(0, 7));
        have = 1'b1;
      end
      in_valid = ($urandom_range(0, 9) < 7);
      in_data = d; in_error = e; in_startofpacket = s; in_endofpacket = p; in_empty = m;
      out_ready = $urandom_range(0, 1);
      prev = acc_cnt;
      tick();
      guard++;
      if (acc_cnt != prev) begin
        have = 1'b0;
        sent++;
        if (s) drv_in_pkt = !p;
        else if (p) drv_in_pkt = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("rand_sent", 70'(sent), 70'd1000);
    out_ready = 1'b1;
    if (drv_in_pkt) send_beat(64'hC105E, 1'b0, 1'b0, 1'b1, 3'd0);
    drain();
    check("rand_proto_err", 70'(proto_err), 70'd0);

    // Framing violation: eop beat without sop while idle
    send_beat(64'hDEAD, 1'b0, 1'b0, 1'b1, 3'd0);
    @(negedge clk);
    check("perr_set", 70'(proto_err), 70'd1);
    tick();
    send_beat(64'hBEEF, 1'b0, 1'b1, 1'b1, 3'd1);
    drain();
    check("perr_sticky", 70'(proto_err), 70'd1);

    // Reset in the middle of a buffered packet
    out_ready = 1'b0;
    repeat (3) tick();
    send_beat(64'h1, 1'b0, 1'b1, 1'b0, 3'd0);
    send_beat(64'h2, 1'b0, 1'b0, 1'b0, 3'd0);
    send_beat(64'h3, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    check("mid_level", 70'(fifo_level), 70'd3);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_level", 70'(fifo_level), 70'd0);
    check("mid_rst_out_valid", 70'(out_valid), 70'd0);
    check("mid_rst_proto_err", 70'(proto_err), 70'd0);
    check("mid_rst_pkt_count", 70'(pkt_count), 70'd0);
    tick();

    // Counter wrap: 65537 single-beat packets
    out_ready = 1'b1;
    in_valid = 1'b1; in_error = 1'b0; in_startofpacket = 1'b1; in_endofpacket = 1'b1;
    in_empty = 3'd0;
    prev = acc_cnt; guard = 0;
    while (acc_cnt - prev < 65537 && guard < 70000) begin
      in_data = 64'(guard);
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("wrap_sent", 70'(acc_cnt - prev), 70'd65537);
    drain();
    check("wrap_pkt_count", 70'(pkt_count), 70'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blk_09c70e.md
SONIC_V1_15_PCS_ETH_10G_MAC_TX_TIMING_ADAPTER_FRAME_ENCODER -- requirements
Module: sonic_v1_15_pcs_eth_10g_mac_tx_timing_adapter_frame_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >= READY_LATENCY).
REQ-002 SHALL have parameter READY_LATENCY, default 2, out-side ready latency in cycles (1..3).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_ready  output  1  in-side ready, ready latency 0.
REQ-006 SHALL have port in_valid  input  1  in-side beat valid.
REQ-007 SHALL have port in_data  input  64  beat data.
REQ-008 SHALL have port in_error  input  1  beat error flag.
REQ-009 SHALL have ports in_startofpacket, in_endofpacket  input  1 each  framing.
REQ-010 SHALL have port in_empty  input  3  empty bytes on EOP beat.
REQ-011 SHALL have port out_ready  input  1  sink ready, ready latency READY_LATENCY.
REQ-012 SHALL have ports out_valid, out_data[63:0], out_error, out_startofpacket, out_endofpacket, out_empty[2:0]  output  matching widths.
REQ-013 SHALL have port fifo_level  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port proto_err  output  1  sticky framing violation.
REQ-015 SHALL have port pkt_count  output  16  EOP beats delivered on out side.

Function
REQ-016 Payload SHALL be 70 bits, packed {data, error, sop, eop, empty}, stored unmodified in FIFO.
REQ-017 in_ready SHALL equal (level < DEPTH), derived from registered level only (no in_valid/out_ready path).
REQ-018 Push SHALL occur when in_valid && in_ready; level increments next cycle.
REQ-019 A READY_LATENCY-deep shift register SHALL delay out_ready; rdy_d = out_ready from READY_LATENCY cycles earlier.
REQ-020 out_valid SHALL equal rdy_d && (level != 0); pop occurs in that cycle; out_valid never asserted when rdy_d is low.
REQ-021 out_* payload SHALL be FIFO head, combinational from registered storage; don't-care when out_valid low.
REQ-022 Simultaneous push and pop SHALL leave level unchanged; push into full FIFO SHALL be impossible (in_ready low); pop from empty SHALL not occur.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH.
REQ-024 Sustained in_valid and out_ready high SHALL yield one beat per cycle after initial READY_LATENCY fill.
REQ-025 Framing tracker SHALL have states IDLE and IN_PKT, updated on accepted in-side beats.
REQ-026 IDLE + sop + !eop -> IN_PKT; IDLE + sop + eop -> IDLE; IN_PKT + eop (no sop) -> IDLE.
REQ-027 IDLE + !sop, or IN_PKT + sop, SHALL set proto_err; state follows sop/eop as in REQ-026 (sop wins); beat still forwarded.
REQ-028 proto_err SHALL clear only on reset.
REQ-029 pkt_count SHALL increment on each popped beat with eop set, wrapping 0xFFFF -> 0x0000.

Reset
REQ-030 While reset_n low at clk edge: level=0, pointers=0, delay register=0, state=IDLE, proto_err=0, pkt_count=0.
REQ-031 During and first cycle after reset: in_ready=1 (level 0), out_valid=0; FIFO contents not cleared.
REQ-032 Reset mid-packet SHALL discard all buffered beats; no partial output beat after reset release.

Structure
REQ-033 Payload width (70), field offsets, and state encodings SHALL live in shared package sonic_v1_15_avst_pkg, reused by the RX timing adapter.
REQ-034 FIFO storage/pointers SHALL be a sub-module sonic_v1_15_avst_sc_fifo (parameter DEPTH, WIDTH); ready delay and framing tracker stay in top.

Verification
REQ-035 Single beat: in sop=eop=1, data=0x0123456789ABCDEF, empty=3, out_ready held 1 -> out_valid at cycle 2 with identical payload; pkt_count=1.
REQ-036 Backpressure: out_ready=0, 6 beats offered -> in_ready drops after 4 accepted, fifo_level=4; out_ready=1 at T -> first out_valid at T+2, beats in order.
REQ-037 Latency honour: random out_ready pattern, 1000 beats -> out_valid only where out_ready was high 2 cycles earlier; zero loss, zero duplication.
REQ-038 Framing: beat without sop in IDLE -> proto_err=1 next cycle, beat still delivered; remains 1 until reset.
REQ-039 Reset mid-packet with level=3 -> level=0, out_valid=0, proto_err=0, pkt_count=0 after one clk.
REQ-040 Wrap: 65537 single-beat packets -> pkt_count=0x0001.
